fifo_tx_drain: RTL and testbench
================================

Name: fifo_tx_drain

Overview:
- Read-side consumer of the clock-domain-crossing FIFO. Runs in the FIFO read clock domain.
- Pops one word at a time while the FIFO is non-empty and hands it to the serial transmitter using its P_DATA / DATA_VALID / BUSY handshake.
- Adds a programmable inter-frame gap, a missed-handshake retry and a transmitted-word counter.
- Placement: FIFO read port in, UART TX parallel input out.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and TX parallel data.
- GAP_CYCLES, 0, idle clocks inserted after each completed frame (0 = none).
- ACK_TIMEOUT, 4, clocks to wait for TX_BUSY rise after DATA_VALID before re-issuing DATA_VALID (≥1).
- CNT_WIDTH, 16, width of transmitted-word counter.

Ports:
- CLK  in  1  FIFO read clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  permits new pops; sampled only in IDLE.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RD_DATA  in  DATA_WIDTH  FIFO head word; valid whenever FIFO_EMPTY=0.
- FIFO_R_INC  out  1  pop strobe to FIFO.
- TX_BUSY  in  1  transmitter busy.
- TX_P_DATA  out  DATA_WIDTH  word to transmitter.
- TX_DATA_VALID  out  1  one-cycle load strobe to transmitter.
- ACTIVE  out  1  high whenever state≠IDLE.
- RETRY_ERR  out  1  sticky; set on any handshake retry.
- WORD_CNT  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
Reset (RST=1 at a rising edge, any state):
- State goes to IDLE; data register, gap counter, timeout counter, WORD_CNT and RETRY_ERR clear to 0.
- In-flight frame is abandoned. No pop occurs in the reset cycle.
- Outputs after reset: FIFO_R_INC=0, TX_DATA_VALID=0, TX_P_DATA=0, ACTIVE=0, RETRY_ERR=0, WORD_CNT=0.

Datapath:
- FIFO_R_INC is combinational: (state==IDLE) && ENABLE && !FIFO_EMPTY && !RST.
- In that same cycle FIFO_RD_DATA is captured into the data register.
- Exactly one pop per frame. Never pops when FIFO_EMPTY=1.
- TX_P_DATA is driven from the data register and is stable from LOAD until return to IDLE.

FSM states and transitions:
- IDLE: on pop condition go to LOAD; otherwise stay.
- LOAD:
  - TX_DATA_VALID=1 for this single cycle.
  - Timeout counter cleared.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - If TX_BUSY=1, go to SEND.
  - Otherwise increment the timeout counter.
  - When the counter reaches ACK_TIMEOUT with TX_BUSY still 0: set RETRY_ERR and go to LOAD (same word, no new pop).
- SEND:
  - Wait for TX_BUSY=0.
  - On that cycle, increment WORD_CNT.
  - Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES clocks, then go to IDLE.

Timing and boundary rules:
- Latency: pop cycle → TX_DATA_VALID on the next clock.
- Minimum frame-to-frame spacing: TX_BUSY fall → next pop in IDLE is 1 clock later, plus GAP_CYCLES.
- ENABLE deasserted mid-frame: the current frame completes; the next pop is inhibited.
- FIFO going empty mid-frame has no effect; the word is already captured.
- TX_BUSY already 1 during LOAD: WAIT_ACK sees it and proceeds to SEND.
- WORD_CNT at all-ones plus a completion wraps to 0.
- RETRY_ERR is cleared only by RST.

Test Plan:
1. Reset, then load FIFO with 0xA5, ENABLE=1, TX model BUSY rises 1 clk after valid and stays high 10 clks -> one FIFO_R_INC pulse; TX_DATA_VALID the next clk with TX_P_DATA=0xA5; WORD_CNT=1; ACTIVE falls 1 clk after BUSY falls.
2. FIFO holds 0x11,0x22,0x33, GAP_CYCLES=3 -> three frames in order; exactly 3 pops; ≥4 clks between each BUSY fall and the next pop; WORD_CNT=3; FIFO_EMPTY=1 at end with no further pops.
3. TX model ignores the first DATA_VALID, ACK_TIMEOUT=4 -> DATA_VALID re-issued 5 clks after the first with the same word; RETRY_ERR=1; still only one pop; frame completes and WORD_CNT increments once.
4. ENABLE dropped during SEND of 0x5A with 0x6B still queued -> 0x5A completes; no pop of 0x6B until ENABLE returns; then 0x6B is sent.
5. RST asserted during SEND -> next clk all outputs 0 and state IDLE; with ENABLE=1 and data present, a pop occurs the first clk after RST drops.
6. CNT_WIDTH=4, 17 frames -> WORD_CNT reads 15 after frame 15, 0 after frame 16, 1 after frame 17.

Source files
------------

// File: rtl/fifo_tx_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tx_drain_if
// Brief    : FIFO read port and UART TX parallel-load handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_tx_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_R_INC;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;

  // master = drain engine, slave = FIFO read port plus transmitter
  modport master (
    input  FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
    output FIFO_R_INC, TX_P_DATA, TX_DATA_VALID
  );

  modport slave (
    output FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
    input  FIFO_R_INC, TX_P_DATA, TX_DATA_VALID
  );
endinterface
`default_nettype wire

// File: rtl/fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tx_drain
// Brief    : Pops CDC FIFO words and loads them into the serial transmitter,
//            with inter-frame gap, handshake retry and word counter.
// Revision : 1.0  initial release
// ============================================================================
module fifo_tx_drain #(
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  wire logic                 CLK,
  input  wire logic                 RST,
  input  wire logic                 ENABLE,
  fifo_tx_drain_if.master           bus,
  output logic                      ACTIVE,
  output logic                      RETRY_ERR,
  output logic [CNT_WIDTH-1:0]      WORD_CNT
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [TMO_W-1:0]      tmo_q,   tmo_d;
  logic [GAP_W-1:0]      gap_q,   gap_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  retry_q, retry_d;
  logic                  pop;

  always_comb begin
    // RST gates the pop so the FIFO never loses a word to a frame we abandon
    pop     = (state_q == S_IDLE) && ENABLE && !bus.FIFO_EMPTY && !RST;
    state_d = state_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d  = bus.FIFO_RD_DATA;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.TX_BUSY) begin
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_LAST) begin
            retry_d = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_SEND: begin
        if (!bus.TX_BUSY) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  assign bus.FIFO_R_INC    = pop;
  assign bus.TX_P_DATA     = data_q;
  assign bus.TX_DATA_VALID = (state_q == S_LOAD);
  assign ACTIVE            = (state_q != S_IDLE);
  assign RETRY_ERR         = retry_q;
  assign WORD_CNT          = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_tx_drain
// Brief    : Directed bench for fifo_tx_drain with FIFO and transmitter models.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_tx_drain;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        act_a, act_b, rerr_a, rerr_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  fifo_tx_drain_if #(.DATA_WIDTH(8)) if_a ();
  fifo_tx_drain_if #(.DATA_WIDTH(8)) if_b ();

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(0), .ACK_TIMEOUT(4), .CNT_WIDTH(16)) u_dut_a (
    .CLK(CLK), .RST(RST), .ENABLE(en_a), .bus(if_a.master),
    .ACTIVE(act_a), .RETRY_ERR(rerr_a), .WORD_CNT(cnt_a));

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(3), .ACK_TIMEOUT(4), .CNT_WIDTH(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .ENABLE(en_b), .bus(if_b.master),
    .ACTIVE(act_b), .RETRY_ERR(rerr_b), .WORD_CNT(cnt_b));

  always #5 CLK = ~CLK;

  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          rem[2], ign[2], pops[2], valids[2], v_cyc[2], v_prev[2];
  int          busy_fall[2], act_fall[2], min_gap[2];
  logic [31:0] hist[2];
  logic        busy_m[2], act_prev[2];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return (i == 0) ? {16'h0, cnt_a} : {28'h0, cnt_b};
  endfunction

  task automatic sync_models();
    if_a.FIFO_EMPTY   = (q_a.size() == 0);
    if_a.FIFO_RD_DATA = (q_a.size() != 0) ? q_a[0] : 8'h00;
    if_b.FIFO_EMPTY   = (q_b.size() == 0);
    if_b.FIFO_RD_DATA = (q_b.size() != 0) ? q_b[0] : 8'h00;
    if_a.TX_BUSY      = busy_m[0];
    if_b.TX_BUSY      = busy_m[1];
    #1;
  endtask

  // One clock: sample pre-edge strobes, advance FIFO and transmitter models
  task automatic tick();
    logic [1:0] inc, vld;
    logic [7:0] pd[2];
    logic       a, nb;
    inc   = {if_b.FIFO_R_INC, if_a.FIFO_R_INC};
    vld   = {if_b.TX_DATA_VALID, if_a.TX_DATA_VALID};
    pd[0] = if_a.TX_P_DATA;
    pd[1] = if_b.TX_P_DATA;
    for (int i = 0; i < 2; i++) begin
      if (inc[i]) begin
        pops[i]++;
        if (cyc - busy_fall[i] < min_gap[i]) min_gap[i] = cyc - busy_fall[i];
      end
      if (vld[i]) begin
        valids[i]++;
        v_prev[i] = v_cyc[i];
        v_cyc[i]  = cyc;
        hist[i]   = {hist[i][23:0], pd[i]};
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (inc[0] && q_a.size() > 0) void'(q_a.pop_front());
    if (inc[1] && q_b.size() > 0) void'(q_b.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (vld[i]) begin
        if (ign[i] > 0) ign[i]--;
        else rem[i] = 10;
      end else if (rem[i] > 0) begin
        rem[i]--;
      end
      nb = (rem[i] != 0);
      if (busy_m[i] && !nb) busy_fall[i] = cyc;
      busy_m[i] = nb;
    end
    sync_models();
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? act_a : act_b;
      if (act_prev[i] && !a) act_fall[i] = cyc;
      act_prev[i] = a;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; ign[i] = 0; pops[i] = 0; valids[i] = 0;
      v_cyc[i] = -100; v_prev[i] = -100; busy_fall[i] = -1000;
      act_fall[i] = -1; min_gap[i] = 1000; hist[i] = '0; busy_m[i] = 1'b0;
    end
    q_a.delete();
    q_b.delete();
    sync_models();
  endtask

  task automatic do_reset();
    en_a = 1'b0;
    en_b = 1'b0;
    RST  = 1'b1;
    clear_model();
    tick();
    tick();
    RST = 1'b0;
    sync_models();
  endtask

  task automatic run_cnt(input int i, input int target, input int budget, input string tag);
    int n = 0;
    while (cnt_of(i) != target && n < budget) begin
      tick();
      n++;
    end
    check_vec(tag, cnt_of(i), target);
  endtask

  initial begin
    // single word, reset values and latency
    do_reset();
    check_vec("rst_rinc",   {31'h0, if_a.FIFO_R_INC},    32'h0);
    check_vec("rst_valid",  {31'h0, if_a.TX_DATA_VALID}, 32'h0);
    check_vec("rst_pdata",  {24'h0, if_a.TX_P_DATA},     32'h0);
    check_vec("rst_active", {31'h0, act_a},              32'h0);
    check_vec("rst_retry",  {31'h0, rerr_a},             32'h0);
    check_vec("rst_cnt",    cnt_of(0),                   32'h0);
    q_a.push_back(8'hA5);
    en_a = 1'b1;
    sync_models();
    check_vec("t1_rinc", {31'h0, if_a.FIFO_R_INC}, 32'h1);
    tick();
    check_vec("t1_valid", {31'h0, if_a.TX_DATA_VALID}, 32'h1);
    check_vec("t1_pdata", {24'h0, if_a.TX_P_DATA},     32'hA5);
    run_cnt(0, 1, 40, "t1_cnt");
    check_vec("t1_pops",    pops[0],                      1);
    check_vec("t1_valids",  valids[0],                    1);
    check_vec("t1_act_lag", act_fall[0] - busy_fall[0],   1);

    // three words with a 3-clock gap
    do_reset();
    q_b.push_back(8'h11);
    q_b.push_back(8'h22);
    q_b.push_back(8'h33);
    en_b = 1'b1;
    sync_models();
    run_cnt(1, 3, 200, "t2_cnt");
    repeat (10) tick();
    check_vec("t2_order", {8'h0, hist[1][23:0]},        32'h112233);
    check_vec("t2_pops",  pops[1],                      3);
    check_vec("t2_gap",   min_gap[1],                   4);
    check_vec("t2_empty", {31'h0, if_b.FIFO_EMPTY},     32'h1);
    check_vec("t2_idle",  {31'h0, act_b},               32'h0);

    // first load ignored -> retry of the same word
    do_reset();
    ign[0] = 1;
    q_a.push_back(8'h3C);
    en_a = 1'b1;
    sync_models();
    run_cnt(0, 1, 60, "t3_cnt");
    check_vec("t3_respace", v_cyc[0] - v_prev[0],     5);
    check_vec("t3_sameword", {16'h0, hist[0][15:0]},  32'h3C3C);
    check_vec("t3_retry",   {31'h0, rerr_a},          32'h1);
    check_vec("t3_pops",    pops[0],                  1);
    check_vec("t3_valids",  valids[0],                2);

    // enable dropped mid-frame
    do_reset();
    q_a.push_back(8'h5A);
    q_a.push_back(8'h6B);
    en_a = 1'b1;
    sync_models();
    repeat (4) tick();
    check_vec("t4_in_send", {31'h0, act_a}, 32'h1);
    en_a = 1'b0;
    sync_models();
    run_cnt(0, 1, 40, "t4_cnt1");
    repeat (6) tick();
    check_vec("t4_inhibit", pops[0],                   1);
    check_vec("t4_held",    {31'h0, if_a.FIFO_EMPTY},  32'h0);
    check_vec("t4_idle",    {31'h0, act_a},            32'h0);
    en_a = 1'b1;
    sync_models();
    run_cnt(0, 2, 40, "t4_cnt2");
    check_vec("t4_words", {16'h0, hist[0][15:0]}, 32'h5A6B);
    check_vec("t4_pops",  pops[0],                2);

    // reset during SEND
    do_reset();
    q_a.push_back(8'h77);
    q_a.push_back(8'h88);
    en_a = 1'b1;
    sync_models();
    repeat (4) tick();
    RST = 1'b1;
    sync_models();
    tick();
    check_vec("t5_rinc",   {31'h0, if_a.FIFO_R_INC},    32'h0);
    check_vec("t5_valid",  {31'h0, if_a.TX_DATA_VALID}, 32'h0);
    check_vec("t5_pdata",  {24'h0, if_a.TX_P_DATA},     32'h0);
    check_vec("t5_active", {31'h0, act_a},              32'h0);
    check_vec("t5_cnt",    cnt_of(0),                   32'h0);
    RST = 1'b0;
    sync_models();
    check_vec("t5_pop_after", {31'h0, if_a.FIFO_R_INC}, 32'h1);
    tick();
    check_vec("t5_pdata2", {24'h0, if_a.TX_P_DATA},     32'h88);
    check_vec("t5_valid2", {31'h0, if_a.TX_DATA_VALID}, 32'h1);
    check_vec("t5_pops",   pops[0],                     2);
    run_cnt(0, 1, 60, "t5_cnt_done");

    // 4-bit counter wrap over 17 frames
    do_reset();
    for (int w = 0; w < 17; w++) q_b.push_back(8'(w + 1));
    en_b = 1'b1;
    sync_models();
    for (int f = 1; f <= 14; f++) run_cnt(1, f, 40, $sformatf("t6_frame%0d", f));
    run_cnt(1, 15, 40, "t6_frame15");
    run_cnt(1, 0,  40, "t6_frame16");
    run_cnt(1, 1,  40, "t6_frame17");
    check_vec("t6_pops", pops[1], 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
